// File: rtl/alu_share_arbiter_if.sv
// Requester and ALU-side signals of the shared-ALU arbiter; master drives requests and ALU results,
// slave is the arbiter that latches operands and returns results.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [2:0]       gin0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [2:0]       gin1;

  logic             gnt0;
  logic             gnt1;
  logic             rvalid0;
  logic             rvalid1;
  logic [WIDTH-1:0] rdata;
  logic             rzero;
  logic             rerr;
  logic             busy;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_gin;
  logic [WIDTH-1:0] alu_sum;
  logic             alu_zout;

  modport master (
    output req0, a0, b0, gin0, req1, a1, b1, gin1, alu_sum, alu_zout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, rzero, rerr, busy, alu_a, alu_b, alu_gin
  );

  modport slave (
    input  req0, a0, b0, gin0, req1, a1, b1, gin1, alu_sum, alu_zout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, rzero, rerr, busy, alu_a, alu_b, alu_gin
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one combinational ALU; grant pulse one edge after req, result pulse one edge later.
// One op per 2 cycles; requests arriving during EXEC wait and are sampled at the RESP edge.
module alu_share_arbiter #(
  parameter int WIDTH     = 32,
  parameter bit FIXED_PRI = 1'b0
) (
  input logic            clk,
  input logic            reset,
  alu_share_arbiter_if.slave bus
);

  localparam logic [2:0] GIN_ADD = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic             illegal;

  logic             any_req;
  logic             pick1;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [2:0]       win_gin;
  logic             win_illegal;

  // last holds the id served most recently; on a tie the other requester wins
  always_comb begin
    any_req     = bus.req0 | bus.req1;
    pick1       = bus.req1 & (~bus.req0 | (~FIXED_PRI & ~last));
    win_a       = pick1 ? bus.a1   : bus.a0;
    win_b       = pick1 ? bus.b1   : bus.b0;
    win_gin     = pick1 ? bus.gin1 : bus.gin0;
    win_illegal = (win_gin == 3'b011) || (win_gin == 3'b101);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      illegal     <= 1'b0;
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      bus.rdata   <= '0;
      bus.rzero   <= 1'b0;
      bus.rerr    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
      bus.alu_gin <= GIN_ADD;
    end else begin
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (any_req) begin
            state       <= EXEC;
            bus.busy    <= 1'b1;
            owner       <= pick1;
            last        <= pick1;
            bus.gnt0    <= ~pick1;
            bus.gnt1    <= pick1;
            bus.alu_a   <= win_a;
            bus.alu_b   <= win_b;
            // undefined codes never reach the ALU; the result is forced at EXEC instead
            bus.alu_gin <= win_illegal ? GIN_ADD : win_gin;
            illegal     <= win_illegal;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        EXEC: begin
          state    <= RESP;
          bus.busy <= 1'b1;
          if (illegal) begin
            bus.rdata <= '0;
            bus.rzero <= 1'b1;
            bus.rerr  <= 1'b1;
          end else begin
            bus.rdata <= bus.alu_sum;
            bus.rzero <= bus.alu_zout;
            bus.rerr  <= 1'b0;
          end
          bus.rvalid0 <= ~owner;
          bus.rvalid1 <= owner;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU instance (combinational; control codes 010 ADD, 110 SUB, 111 SLT, 000 AND, 001 OR, 100 NOR) between two requesters.
- The block arbitrates requests, latches operands and drives the ALU inputs from registers. It captures sum and zero flag and returns them to the winning requester with a one-cycle valid pulse.
- It sits between datapath clients (for example a branch-compare unit and an address-calc unit) and the single ALU.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU (32).
- FIXED_PRI, 0, 0 = round-robin; 1 = requester 0 always wins a tie.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 has an op pending
- a0  input  WIDTH  requester 0 operand a
- b0  input  WIDTH  requester 0 operand b
- gin0  input  3  requester 0 ALU control code
- req1  input  1  requester 1 has an op pending
- a1  input  WIDTH  requester 1 operand a
- b1  input  WIDTH  requester 1 operand b
- gin1  input  3  requester 1 ALU control code
- gnt0  output  1  one-cycle pulse: requester 0 operands latched
- gnt1  output  1  one-cycle pulse: requester 1 operands latched
- rvalid0  output  1  one-cycle pulse: result for requester 0 on rdata
- rvalid1  output  1  one-cycle pulse: result for requester 1 on rdata
- rdata  output  WIDTH  captured ALU sum
- rzero  output  1  captured ALU zero flag
- rerr  output  1  op had an unsupported control code
- busy  output  1  high whenever state != IDLE
- alu_a  output  WIDTH  to ALU operand a (registered)
- alu_b  output  WIDTH  to ALU operand b (registered)
- alu_gin  output  3  to ALU control line (registered)
- alu_sum  input  WIDTH  from ALU sum
- alu_zout  input  1  from ALU zero flag

Behaviour:
- Reset (async, any state): state=IDLE; gnt0/1=0, rvalid0/1=0, rdata=0, rzero=0, rerr=0, busy=0; alu_a=0, alu_b=0, alu_gin=3'b010. Round-robin pointer prefers requester 0. Any in-flight op is discarded and no rvalid is issued for it.
- States: IDLE, EXEC, RESP. All outputs are registered.
- Grant edge: taken in IDLE or RESP when req0|req1.
  - Latch the winner's a/b/gin into alu_a/alu_b/alu_gin and the owner id.
  - Pulse the winner's gnt for one cycle and go to EXEC.
- Arbitration:
  - Single requester wins outright.
  - Both requesting with FIXED_PRI=1: requester 0 wins.
  - Both requesting with FIXED_PRI=0: the requester not served last wins; the pointer updates on every grant.
- EXEC edge:
  - rdata<=alu_sum, rzero<=alu_zout, rerr<=0.
  - Pulse rvalid of the owner; go to RESP.
- Unsupported gin (011, 101): the latched code is replaced by 3'b010 on alu_gin so the ALU never sees an undefined code. At the EXEC edge, rdata<=0, rzero<=1, rerr<=1, and rvalid pulses as normal.
- RESP edge: if no req, go to IDLE. rvalid, rdata, rzero and rerr stay as described: rvalid drops, data holds until the next EXEC edge.
- Latency: req high before edge E0 → gnt high E0–E1 → rvalid high E1–E2. Back-to-back throughput is one op per 2 cycles (grant taken from RESP).
- Requester rule: hold req/a/b/gin stable until gnt is seen. Drop req by edge E2 unless presenting a new op; a req still high at E2 is treated as a new op.
- Req during EXEC is ignored, not lost; it is sampled at the RESP edge.
- alu_a/alu_b/alu_gin hold their last value outside grant edges.
- gnt0 and gnt1 are never high together; rvalid0 and rvalid1 are never high together.

Test Plan:
- Single ADD: req0 with a0=5, b0=7, gin0=010 → gnt0 after E0; rvalid0 after E1 with rdata=12, rzero=0, rerr=0; busy high E0–E2.
- SUB zero: req1 with a1=b1=32'h1234, gin1=110 → rvalid1, rdata=0, rzero=1.
- Contention, round-robin (FIXED_PRI=0): both requests held continuously, ops ADD and OR → grants alternate 0,1,0,1 at 2-cycle spacing; each rvalid matches its owner's result.
- FIXED_PRI=1: both requests held → gnt0 every grant, requester 1 starved until req0 drops, then gnt1.
- Illegal code: gin0=011 → alu_gin=010; rvalid0 with rdata=0, rzero=1, rerr=1.
- Reset mid-op: assert reset during EXEC → outputs return to reset values immediately, no rvalid. After release, req1 wins immediately because the pointer prefers 0 only when both request.
